// File: rtl/move_engine.sv
// move_engine: applies one 2048 move (slide + merge) to a 4x4 board,
// accumulates the merge score and spawns one new tile when the board changed.
module move_engine #(
  parameter int          CELL_W    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    dir,
  input  logic [0:3][0:3][CELL_W-1:0]   board_in,
  output logic [0:3][0:3][CELL_W-1:0]   board_out,
  output logic                          busy,
  output logic                          done,
  output logic                          moved,
  output logic [15:0]                   score_delta
);

  typedef logic [0:3][0:3][CELL_W-1:0] board_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SLIDE, S_SPAWN, S_DONE} state_t;

  // Tiles at or above this value never merge, so a cell cannot overflow.
  localparam logic [CELL_W-1:0] MERGE_CAP = CELL_W'(2048);

  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  line_q, line_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  scan_q, scan_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] lfsr_q, lfsr_d;
  board_t      work_q, work_d;
  board_t      shadow_q, shadow_d;
  board_t      board_out_q, board_out_d;
  logic        moved_q, moved_d;
  logic [15:0] score_q, score_d;

  // Scratch values for the line currently being slid.
  logic [CELL_W-1:0] in_l     [4];
  logic [CELL_W-1:0] comp     [4];
  logic [CELL_W-1:0] comp_nxt [4];
  logic [CELL_W-1:0] out_l    [4];
  logic [CELL_W-1:0] merged;
  logic [1:0]        cnt;
  logic [1:0]        wr;
  logic              skip;
  logic [3:0]        idx;
  logic [15:0]       line_sum;
  board_t            slid_board;
  logic              slide_moved;
  logic [CELL_W-1:0] spawn_cell;

  // Position p (0 = leading end) of line i for direction d, returned as {row, col}.
  function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] i,
                                          input logic [1:0] p);
    case (d)
      2'd0:    cell_idx = {p, i};
      2'd1:    cell_idx = {~p, i};
      2'd2:    cell_idx = {i, p};
      default: cell_idx = {i, ~p};
    endcase
  endfunction

  // Slide datapath: gather one line, compact it, merge pairs, scatter it back.
  always_comb begin
    idx        = '0;
    merged     = '0;
    cnt        = '0;
    wr         = '0;
    skip       = 1'b0;
    line_sum   = '0;
    slid_board = work_q;
    for (int p = 0; p < 4; p++) begin
      in_l[p]  = '0;
      comp[p]  = '0;
      out_l[p] = '0;
    end
    for (int p = 0; p < 4; p++) begin
      idx     = cell_idx(dir_q, line_q, 2'(p));
      in_l[p] = work_q[idx[3:2]][idx[1:0]];
    end
    for (int p = 0; p < 4; p++) begin
      if (in_l[p] != '0) begin
        comp[cnt] = in_l[p];
        cnt       = cnt + 2'd1;
      end
    end
    comp_nxt[0] = comp[1];
    comp_nxt[1] = comp[2];
    comp_nxt[2] = comp[3];
    comp_nxt[3] = '0;
    for (int j = 0; j < 4; j++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[j] != '0) begin
        if (comp[j] == comp_nxt[j] && comp[j] < MERGE_CAP) begin
          merged    = comp[j] << 1;
          out_l[wr] = merged;
          line_sum  = line_sum + 16'(merged);
          skip      = 1'b1;
        end else begin
          out_l[wr] = comp[j];
        end
        wr = wr + 2'd1;
      end
    end
    for (int p = 0; p < 4; p++) begin
      idx = cell_idx(dir_q, line_q, 2'(p));
      slid_board[idx[3:2]][idx[1:0]] = out_l[p];
    end
    slide_moved = (slid_board != shadow_q);
  end

  assign spawn_cell = work_q[k_q[3:2]][k_q[1:0]];

  // Control FSM next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    line_d      = line_q;
    k_d         = k_q;
    scan_d      = scan_q;
    acc_d       = acc_q;
    lfsr_d      = lfsr_q;
    work_d      = work_q;
    shadow_d    = shadow_q;
    board_out_d = board_out_q;
    moved_d     = moved_q;
    score_d     = score_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = dir;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        work_d   = board_in;
        shadow_d = board_in;
        acc_d    = '0;
        line_d   = '0;
        state_d  = S_SLIDE;
      end
      S_SLIDE: begin
        work_d = slid_board;
        acc_d  = acc_q + line_sum;
        line_d = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (slide_moved) begin
            k_d     = lfsr_q[3:0];
            scan_d  = '0;
            state_d = S_SPAWN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SPAWN: begin
        if (spawn_cell == '0) begin
          work_d[k_q[3:2]][k_q[1:0]] = (lfsr_q[7:4] == 4'd0) ? CELL_W'(4) : CELL_W'(2);
          state_d = S_DONE;
        end else begin
          k_d    = k_q + 4'd1;
          scan_d = scan_q + 4'd1;
          if (scan_q == 4'd15) state_d = S_DONE;
        end
      end
      S_DONE: begin
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Publish results as DONE is entered so they are valid during the done pulse.
    if (state_d == S_DONE && state_q != S_DONE) begin
      board_out_d = work_d;
      score_d     = acc_d;
      moved_d     = (state_q == S_SPAWN);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dir_q       <= '0;
      line_q      <= '0;
      k_q         <= '0;
      scan_q      <= '0;
      acc_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      work_q      <= '0;
      shadow_q    <= '0;
      board_out_q <= '0;
      moved_q     <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      k_q         <= k_d;
      scan_q      <= scan_d;
      acc_q       <= acc_d;
      lfsr_q      <= lfsr_d;
      work_q      <= work_d;
      shadow_q    <= shadow_d;
      board_out_q <= board_out_d;
      moved_q     <= moved_d;
      score_q     <= score_d;
    end
  end

  assign board_out   = board_out_q;
  assign score_delta = score_q;
  assign moved       = moved_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

endmodule
